// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmit and receive blocks: channel
// encoding on ws, default word width and default capture FIFO depth.
package i2s_pkg;

  // ws level selects the channel of the word being shifted.
  typedef enum logic {
    I2S_WS_LEFT  = 1'b0,
    I2S_WS_RIGHT = 1'b1
  } i2s_ch_e;

  localparam int I2S_DEFAULT_RESOLUTION = 16;
  localparam int I2S_DEFAULT_DEPTH      = 512;

  // Bit counter is wide enough to notice any word far longer than 16 bits.
  localparam int         I2S_BITCNT_W   = 5;
  localparam logic [4:0] I2S_BITCNT_MAX = 5'd31;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous show-ahead FIFO for captured I2S words. The head entry is
// always visible on o_data; o_data reads zero while the FIFO is empty.
module i2s_rx_fifo #(
  parameter int width = 17,
  parameter int depth = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [width-1:0]         i_data,
  input  logic                     i_pop,
  output logic [width-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(depth):0]   o_level
);

  localparam int AW      = $clog2(depth);
  localparam int LEVEL_W = AW + 1;

  logic [width-1:0] r_mem [depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == LEVEL_W'(depth));
  assign w_empty = (r_wptr == r_rptr);
  assign w_rd    = i_pop & ~w_empty;
  // A push into a full FIFO only lands when a pop frees a slot that cycle.
  assign w_wr    = i_push & (~w_full | w_rd);

  // Advance write and read pointers; both wrap modulo depth naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes an external sck/ws/sd bus into clk, deserializes
// MSB-first words, tags them with their channel and queues them in a FIFO
// drained through a valid/ready stream.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int freq_hz    = 60_000_000,
  parameter int resolution = I2S_DEFAULT_RESOLUTION,
  parameter int depth      = I2S_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   ws,
  input  logic                   sd,
  output logic [15:0]            dout,
  output logic                   dout_ch,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(depth):0] level,
  output logic                   overrun,
  output logic                   frame_err
);

  // sck must stay high and low for at least 3 clk, so its rate tops out here.
  localparam int MaxSckHz = freq_hz / 6;

  logic                    r_sck_s1, r_sck_s2, r_sck_s3;
  logic                    r_ws_s1, r_ws_s2;
  logic                    r_sd_s1, r_sd_s2;
  i2s_ch_e                 r_ws_prev;
  // Holds the earlier bits of the word; the current bit joins it on the fly.
  logic [resolution-2:0]   r_shift;
  logic [I2S_BITCNT_W-1:0] r_bitcnt;
  logic                    r_armed;
  logic                    r_frame_err;
  logic                    r_overrun;

  logic                    w_rise;
  logic                    w_boundary;
  logic                    w_count_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [resolution-1:0]   w_word;
  logic [I2S_BITCNT_W-1:0] w_bitcnt_next;
  logic [16:0]             w_push_data;
  logic [16:0]             w_head;

  assign w_rise        = r_sck_s2 & ~r_sck_s3;
  assign w_word        = {r_shift, r_sd_s2};
  assign w_bitcnt_next = (r_bitcnt == I2S_BITCNT_MAX) ? r_bitcnt : r_bitcnt + 1'b1;
  // ws flips one bit early, so the bit sampled at the flip closes the old word.
  assign w_boundary    = w_rise & (i2s_ch_e'(r_ws_s2) != r_ws_prev);
  assign w_count_ok    = (w_bitcnt_next == I2S_BITCNT_W'(resolution));
  assign w_push        = w_boundary & r_armed & w_count_ok;
  assign w_pop         = valid & ready;
  assign w_push_data   = {r_ws_prev, 16'(w_word)};

  // Two-flop synchronizers for the async bus plus a third sck flop for edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_s3 <= 1'b0;
      r_ws_s1  <= 1'b0;
      r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0;
      r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= sck;
      r_sck_s2 <= r_sck_s1;
      r_sck_s3 <= r_sck_s2;
      r_ws_s1  <= ws;
      r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= sd;
      r_sd_s2  <= r_sd_s1;
    end
  end

  // Deserializer: shift on every sck rise, restart the count at word boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_ws_prev <= I2S_WS_LEFT;
      r_armed   <= 1'b0;
    end else if (w_rise) begin
      r_shift   <= w_word[resolution-2:0];
      r_ws_prev <= i2s_ch_e'(r_ws_s2);
      if (w_boundary) begin
        r_bitcnt <= '0;
        r_armed  <= 1'b1;
      end else begin
        r_bitcnt <= w_bitcnt_next;
      end
    end
  end

  // Status: one-cycle frame error pulse and a sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_boundary & r_armed & ~w_count_ok;
      if (w_push & w_full & ~w_pop) r_overrun <= 1'b1;
    end
  end

  i2s_rx_fifo #(
    .width (17),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign dout      = w_head[15:0];
  assign dout_ch   = w_head[16];
  assign valid     = ~w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  a_params : assert property (@(posedge clk) disable iff (!rst)
    (resolution >= 8) && (resolution <= 16) && (depth >= 2) &&
    ((depth & (depth - 1)) == 0) && (MaxSckHz > 0));

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives an I2S bus bit by bit and predicts the output
// word stream from the framing rules (ws edges close words, first word after
// reset dropped, 16-bit words kept, others flagged) with a queue-based model.
module tb_i2s_rx;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst, sck, ws, sd, ready;
  logic [15:0] dout;
  logic        dout_ch, valid, overrun, frame_err;
  logic [9:0]  level;

  i2s_rx #(
    .freq_hz    (60_000_000),
    .resolution (16),
    .depth      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd),
    .dout      (dout),
    .dout_ch   (dout_ch),
    .valid     (valid),
    .ready     (ready),
    .level     (level),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int half   = 4;

  // Reference model state: expected words waiting in the FIFO, plus framing.
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  bit          m_armed;
  bit          m_ws_prev;
  int          m_nbits;
  logic [31:0] m_acc;
  bit          m_pop_with_push;
  int          n_ferr = 0;
  bit          rnd_run;

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    m_armed         = 0;
    m_ws_prev       = 0;
    m_nbits         = 0;
    m_acc           = '0;
    m_pop_with_push = 0;
  endtask

  // One sampled bit: a ws change closes the word that this bit ends.
  task automatic model_bit(input logic b, input logic w);
    m_nbits++;
    m_acc = {m_acc[30:0], b};
    if (w != m_ws_prev) begin
      if (!m_armed) m_armed = 1;
      else if (m_nbits == 16) begin
        if (exp_q.size() < DEPTH || m_pop_with_push)
          exp_q.push_back({m_ws_prev, m_acc[15:0]});
      end
      m_nbits = 0;
    end
    m_ws_prev = w;
  endtask

  task automatic send_bit(input logic b, input logic w);
    sck = 1'b0; sd = b; ws = w;
    repeat (half) @(posedge clk);
    #1 sck = 1'b1;
    model_bit(b, w);
    repeat (half) @(posedge clk);
    #1;
  endtask

  // Bits n-1..1 go out with ws=ch; the LSB goes out with ws already flipped.
  task automatic send_word(input logic [31:0] v, input int n, input logic ch);
    for (int i = n - 1; i >= 1; i--) send_bit(v[i], ch);
    send_bit(v[0], ~ch);
  endtask

  task automatic do_reset();
    ready = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    half = 4;
    @(posedge clk);
    #1;
  endtask

  // Pop monitor: every accepted word must match the model's next word.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_err === 1'b1) n_ferr++;
      if (valid === 1'b1 && ready === 1'b1) begin
        logic [16:0] e;
        checks++;
        got_q.push_back({dout_ch, dout});
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL pop_unexpected: got %h, expected no word", {dout_ch, dout});
        end else begin
          e = exp_q.pop_front();
          if ({dout_ch, dout} !== e) begin
            errors++;
            $display("[TB] FAIL pop_word: got %h, expected %h", {dout_ch, dout}, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid, dout_ch, dout, level, overrun, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b ch=%b d=%h lvl=%0d ovr=%b fe=%b, expected all 0",
               valid, dout_ch, dout, level, overrun, frame_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || level !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got v=%b lvl=%0d, expected 0 0", valid, level);
    end
  endtask

  task automatic test_basic();
    int f0;
    logic [16:0] w;
    do_reset();
    ready = 1'b1;
    f0 = n_ferr;
    repeat (4) begin
      send_word(32'hA5C3, 16, 1'b0);
      send_word(32'h1234, 16, 1'b1);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d words, expected 7", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      w = got_q[i];
      checks++;
      if (w !== ((i % 2 == 0) ? 17'h11234 : 17'h0A5C3)) begin
        errors++;
        $display("[TB] FAIL basic_word%0d: got %h, expected %h", i, w,
                 (i % 2 == 0) ? 17'h11234 : 17'h0A5C3);
      end
    end
    checks++;
    if (n_ferr != f0) begin
      errors++;
      $display("[TB] FAIL basic_frame_err: got %0d pulses, expected 0", n_ferr - f0);
    end
  endtask

  task automatic test_latency();
    logic [15:0] v;
    int cyc;
    do_reset();
    v = 16'($urandom);
    send_word($urandom, 16, 1'b0);
    for (int i = 15; i >= 1; i--) send_bit(v[i], 1'b1);
    sck = 1'b0; sd = v[0]; ws = 1'b0;
    repeat (half) @(posedge clk);
    #1 sck = 1'b1;
    model_bit(v[0], 1'b0);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 8) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (valid !== 1'b1 || cyc < 1 || cyc > 4) begin
      errors++;
      $display("[TB] FAIL latency: got valid=%b after %0d clk, expected valid within 1..4 clk", valid, cyc);
    end
    checks++;
    if (level !== 10'd1) begin
      errors++;
      $display("[TB] FAIL latency_level: got %0d, expected 1", level);
    end
    checks++;
    if ({dout_ch, dout} !== {1'b1, v}) begin
      errors++;
      $display("[TB] FAIL latency_word: got %h, expected %h", {dout_ch, dout}, {1'b1, v});
    end
    repeat (half) @(posedge clk);
    #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
  endtask

  task automatic test_bad_frame();
    int f0;
    logic [15:0] v;
    do_reset();
    ready = 1'b1;
    f0 = n_ferr;
    v = 16'($urandom);
    send_word($urandom, 16, 1'b0);
    send_word($urandom, 15, 1'b1);
    send_word($urandom, 17, 1'b0);
    send_word({16'h0, v}, 16, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (n_ferr - f0 != 2) begin
      errors++;
      $display("[TB] FAIL bad_frame_pulses: got %0d cycles, expected 2", n_ferr - f0);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, v}) begin
      errors++;
      $display("[TB] FAIL bad_frame_recover: got %0d words first=%h, expected 1 word %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 17'h0, {1'b1, v});
    end
  endtask

  task automatic test_random_ready();
    int f0, cyc;
    logic ch;
    do_reset();
    f0 = n_ferr;
    rnd_run = 1;
    fork
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1 ready = 1'($urandom);
        end
      end
    join_none
    ch = 1'b0;
    for (int i = 0; i < 24; i++) begin
      send_word($urandom, 16, ch);
      ch = ~ch;
    end
    rnd_run = 0;
    repeat (2) @(posedge clk);
    #2 ready = 1'b1;
    cyc = 0;
    while (valid === 1'b1 && cyc < 64) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (got_q.size() != 23 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d words (%0d undelivered), expected 23 (0)",
               got_q.size(), exp_q.size());
    end
    checks++;
    if (n_ferr != f0) begin
      errors++;
      $display("[TB] FAIL random_frame_err: got %0d, expected 0", n_ferr - f0);
    end
  endtask

  // Fill to full, complete one word while popping, overflow, then drain.
  task automatic test_backpressure_full();
    logic ch;
    logic [15:0] v;
    logic [16:0] w;
    int cyc, bad;
    do_reset();
    half = 3;
    send_word(32'hFFFF, 16, 1'b0);
    ch = 1'b1;
    for (int i = 0; i < 512; i++) begin
      send_word(i, 16, ch);
      ch = ~ch;
    end
    checks++;
    if (level !== 10'd512 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: got lvl=%0d ovr=%b, expected 512 0", level, overrun);
    end
    v = 16'd512;
    m_pop_with_push = 1;
    for (int i = 15; i >= 1; i--) send_bit(v[i], ch);
    sck = 1'b0; sd = v[0]; ws = ~ch;
    repeat (half) @(posedge clk);
    #1 sck = 1'b1;
    model_bit(v[0], ~ch);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    m_pop_with_push = 0;
    ch = ~ch;
    checks++;
    if (level !== 10'd512 || overrun !== 1'b0 || got_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL full_pop_push: got lvl=%0d ovr=%b pops=%0d, expected 512 0 1",
               level, overrun, got_q.size());
    end
    for (int i = 513; i < 600; i++) begin
      send_word(i, 16, ch);
      ch = ~ch;
    end
    checks++;
    if (level !== 10'd512 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun: got lvl=%0d ovr=%b, expected 512 1", level, overrun);
    end
    ready = 1'b1;
    cyc = 0;
    while (valid === 1'b1 && cyc < 700) begin
      @(posedge clk);
      #1 cyc++;
    end
    ready = 1'b0;
    checks++;
    if (level !== 10'd0 || got_q.size() != 513) begin
      errors++;
      $display("[TB] FAIL drain_count: got lvl=%0d words=%0d, expected 0 513", level, got_q.size());
    end
    bad = 0;
    for (int k = 0; k < 512 && k + 1 < got_q.size(); k++) begin
      w = got_q[k + 1];
      if (w[15:0] !== 16'(k + 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL drain_order: got %0d out-of-order words, expected 0", bad);
    end
    half = 4;
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] a, c, f, g;
    int f0;
    do_reset();
    a = 16'($urandom) | 16'h0001;
    c = 16'($urandom);
    f = 16'($urandom);
    g = 16'($urandom);
    send_word($urandom, 16, 1'b0);
    send_word({16'h0, a}, 16, 1'b1);
    send_word($urandom, 16, 1'b0);
    for (int i = 15; i >= 9; i--) send_bit(c[i], 1'b1);
    @(posedge clk);
    #1 sck = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (valid !== 1'b1 || level !== 10'd2 || {dout_ch, dout} !== {1'b1, a}) begin
      errors++;
      $display("[TB] FAIL midword_pre: got v=%b lvl=%0d head=%h, expected 1 2 %h",
               valid, level, {dout_ch, dout}, {1'b1, a});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({valid, dout_ch, dout, level, overrun, frame_err} !== '0) begin
      errors++;
      $display("[TB] FAIL midword_async_clear: got v=%b ch=%b d=%h lvl=%0d ovr=%b fe=%b, expected all 0",
               valid, dout_ch, dout, level, overrun, frame_err);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    f0 = n_ferr;
    send_word($urandom, 16, 1'b0);
    send_word({16'h0, f}, 16, 1'b1);
    send_word({16'h0, g}, 16, 1'b0);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1 ready = 1'b0;
    checks++;
    if (got_q.size() != 2 || got_q[0] !== {1'b1, f} || got_q[1] !== {1'b0, g}) begin
      errors++;
      $display("[TB] FAIL midword_recover: got %0d words, expected %h %h",
               got_q.size(), {1'b1, f}, {1'b0, g});
    end
    checks++;
    if (n_ferr != f0) begin
      errors++;
      $display("[TB] FAIL midword_frame_err: got %0d, expected 0", n_ferr - f0);
    end
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_latency();
    test_bad_frame();
    test_random_ready();
    test_backpressure_full();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive-side I2S block: samples an externally driven I2S bus (sck, ws, sd), for example from a codec or MEMS microphone, in the system `clk` domain and deserializes MSB-first words. Completed words are pushed with their channel tag into an on-chip FIFO and drained through a valid/ready stream. It is the capture counterpart of the team's I2S transmitter and uses the same word width and channel convention: ws=0 is left, ws=1 is right.

## Interface
- `freq_hz`, default 60000000: system clock frequency. Documentation and assertion use only.
- `resolution`, default 16: bits per channel word. Legal range 8..16.
- `depth`, default 512: FIFO entries. Must be a power of 2.
- `clk` input, 1 bit: system clock. All state is on its rising edge.
- `rst` input, 1 bit: reset, asynchronous assert, active-low.
- `sck` input, 1 bit: external I2S bit clock. Asynchronous to `clk`.
- `ws` input, 1 bit: external word select. Asynchronous to `clk`.
- `sd` input, 1 bit: external serial data. Asynchronous to `clk`.
- `dout` output, 16 bits: head-of-FIFO word, right-aligned when `resolution` < 16.
- `dout_ch` output, 1 bit: channel of `dout`. 0 = left, 1 = right.
- `valid` output, 1 bit: `dout` and `dout_ch` hold a word.
- `ready` input, 1 bit: consumer accepts the head word.
- `level` output, log2(depth)+1 bits: current FIFO occupancy.
- `overrun` output, 1 bit: sticky. A word was dropped because the FIFO was full.
- `frame_err` output, 1 bit: one-cycle pulse when a word had the wrong bit count.

## Operation
- **Synchronization:** `sck`, `ws` and `sd` each pass through a 2-flop synchronizer. A third `sck` flop drives rising-edge detection, `rise = s2 & ~s3`. Every sampling action happens only in a `rise` cycle.
- **Sampling per `rise`:**
  - shift synchronized `sd` into a `resolution`-bit shift register, MSB first;
  - increment the bit counter, which saturates at 31;
  - keep `ws_prev`, the `ws` value captured at the previous `rise`.
- **Word boundary:** a `rise` where synced `ws` differs from `ws_prev`.
  - The bit sampled in that cycle is the LSB of the word just ending, because standard I2S changes `ws` one bit before the MSB.
  - The completed word's channel is `ws_prev`.
- **Word completion at a boundary:**
  - Bit counter, including the current bit, equals `resolution`: push `{ws_prev, shift register}` into the FIFO.
  - Any other count: no push, and `frame_err` pulses for one cycle.
  - In both cases the bit counter restarts at 0 for the next word.
- **Start-up:** after reset, a `armed` flag stays low until the first boundary. The word completed at that first boundary is discarded silently, with no push and no `frame_err`.
- **FIFO:**
  - Show-ahead: `dout` always shows the head entry.
  - Pop occurs when `valid & ready`.
  - Push while full: the word is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, the word is kept, and `overrun` stays unchanged.
  - Pop while empty is impossible, because `valid` is 0.
  - Pointers wrap modulo `depth`. `level` = write count minus read count.
- **Reset (`rst` = 0), effective immediately:**
  - outputs `valid`=0, `dout`=0, `dout_ch`=0, `level`=0, `overrun`=0, `frame_err`=0;
  - synchronizers, shift register, bit counter and `armed` cleared;
  - FIFO emptied; memory contents are don't-care.
  - Reset in the middle of a word loses that word, and the next first boundary is discarded again.

## Timing
- Requirement: `sck` high time and low time are each ≥ 3 `clk` periods. At the default `freq_hz` this gives `sck` ≤ 10 MHz.
- External `sck` rising edge to the internal `rise` cycle: 2–3 `clk`.
- Push happens in the `rise` cycle that closes the word. `valid` rises on the next `clk` when the FIFO was empty.
- Total latency from the external LSB `sck` edge to `valid`: ≤ 4 `clk`.
- Pop: `dout` advances on the `clk` after the `valid & ready` cycle. Back-to-back pops sustain one word per `clk`.
- `level` updates on the `clk` after the push or pop.
- `frame_err` is high only in the cycle after the bad boundary.
- `overrun` holds until reset.

## Structure
- Shared package `i2s_pkg`, used by both the TX and RX blocks:
  - `I2S_WS_LEFT`=0 and `I2S_WS_RIGHT`=1;
  - default resolution 16;
  - default depth 512.
- Sub-module `i2s_rx_fifo`: synchronous show-ahead FIFO, parameterized by width (17) and `depth`, exposing full, empty and level.
- Synchronizers and the deserializer stay in `i2s_rx`.

## Test plan
- **Basic stream:** after reset, drive `sck` = `clk`/8 with frames L=0xA5C3, R=0x1234, repeated 4 times, `ready`=1. The first boundary's word is discarded. Output must be (0xA5C3, ch 0), (0x1234, ch 1) alternating, with no `frame_err`.
- **Latency:** a single word with `ready`=0. `valid` must rise ≤ 4 `clk` after the external LSB `sck` rising edge, and `level` must read 1.
- **Backpressure:** `ready`=0 while 600 words (counting values 0..599) are sent. `level` must saturate at 512 and `overrun` must go to 1. Draining then yields exactly 0..511 in order.
- **Full with simultaneous pop:** with the FIFO full, assert `ready` in the cycle a word completes. The word must be kept, `level` must stay 512, and `overrun` must stay 0.
- **Bad frame:** a 15-bit word followed by a 17-bit word. Each must pulse `frame_err` once with no push, and the following 16-bit word must be received correctly.
- **Reset mid-word:** assert `rst` low for 2 `clk` after 7 bits of a word. All outputs must clear asynchronously. After release, the first boundary is discarded and later words are correct.
